// File: rtl/scarv_cop_aes_lanes.sv
// AES SubBytes / MixColumns unit for the SCARV co-processor with LANES parallel
// byte lanes; operands are captured at issue and the result is presented in DONE.

module scarv_cop_aes_sbox (
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  logic [7:0] pre;
  logic [7:0] inverse;

  always_comb begin
    pre     = inv ? (rotl(in, 1) ^ rotl(in, 3) ^ rotl(in, 6) ^ 8'h05) : in;
    inverse = gf_inv(pre);
    out     = inv ? inverse
                  : (inverse ^ rotl(inverse, 1) ^ rotl(inverse, 2) ^
                     rotl(inverse, 3) ^ rotl(inverse, 4) ^ 8'h63);
  end

endmodule

module scarv_cop_aes_lanes #(
  parameter int LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        aes_ivalid,
  output logic        aes_idone,
  output logic        aes_busy,
  input  logic [31:0] aes_rs1,
  input  logic [31:0] aes_rs2,
  input  logic [4:0]  id_subclass,
  output logic [3:0]  aes_cpr_rd_ben,
  output logic [31:0] aes_cpr_rd_wdata,
  output logic [1:0]  dbg_state
);

  localparam int STEPS = 4 / LANES;

  // Handshake: aes_ivalid is held high until aes_idone; dropping it during RUN
  // abandons the instruction, dropping it during DONE has no effect.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q;
  logic [31:0] t_q;
  logic [2:0]  sub_q;   // bit0 decrypt, bit1 rotate, bit2 mix
  logic        unsup_q;
  logic [31:0] result_q;

  logic [7:0]  lane_byte [LANES];
  logic [1:0]  lane_dest [LANES];

  logic unused_bits;
  assign unused_bits = ^{aes_rs1[31:24], aes_rs1[15:8], aes_rs2[23:16], aes_rs2[7:0]};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] idx;
    logic [7:0] sb_out;
    logic [7:0] ma, mb, mc, md;

    assign idx = 2'(int'(step_q) * LANES + l);

    scarv_cop_aes_sbox u_sbox (
      .in  (t_q[8*idx +: 8]),
      .inv (sub_q[0]),
      .out (sb_out)
    );

    // Result byte i takes coefficient 2 (enc) / e (dec) from t[3-i], then rotates.
    assign ma = t_q[8*(2'd3 - idx) +: 8];
    assign mb = t_q[8*(2'd0 - idx) +: 8];
    assign mc = t_q[8*(2'd1 - idx) +: 8];
    assign md = t_q[8*(2'd2 - idx) +: 8];

    assign lane_byte[l] = !sub_q[2] ? sb_out :
                          sub_q[0]  ? (gf_mul(ma, 8'h0e) ^ gf_mul(mb, 8'h0b) ^
                                       gf_mul(mc, 8'h0d) ^ gf_mul(md, 8'h09))
                                    : (gf_mul(ma, 8'h02) ^ gf_mul(mb, 8'h03) ^ mc ^ md);
    assign lane_dest[l] = (!sub_q[2] && sub_q[1]) ? idx + 2'd1 : idx;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (aes_ivalid) state_d = (id_subclass < 5'd6) ? S_RUN : S_DONE;
      S_RUN: begin
        if (!aes_ivalid)                  state_d = S_IDLE;
        else if (step_q == 2'(STEPS - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= S_IDLE;
      step_q   <= 2'd0;
      t_q      <= 32'h0;
      sub_q    <= 3'd0;
      unsup_q  <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          step_q <= 2'd0;
          if (aes_ivalid) begin
            t_q      <= {aes_rs2[31:24], aes_rs1[23:16], aes_rs2[15:8], aes_rs1[7:0]};
            sub_q    <= id_subclass[2:0];
            unsup_q  <= !(id_subclass < 5'd6);
            result_q <= 32'h0;
          end
        end
        S_RUN: begin
          step_q <= step_q + 2'd1;
          for (int l = 0; l < LANES; l++) result_q[8*lane_dest[l] +: 8] <= lane_byte[l];
        end
        default: step_q <= 2'd0;
      endcase
    end
  end

  assign aes_idone        = (state_q == S_DONE);
  assign aes_busy         = (state_q != S_IDLE);
  assign aes_cpr_rd_ben   = (state_q == S_DONE && !unsup_q) ? 4'hF : 4'h0;
  assign aes_cpr_rd_wdata = (state_q == S_DONE) ? result_q : 32'h0;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_scarv_cop_aes_lanes.sv
// Directed bench for scarv_cop_aes_lanes: LANES=1,2,4 instances run the same vectors.

module tb_scarv_cop_aes_lanes;

  localparam logic [4:0] SUB_ENC    = 5'b00000;
  localparam logic [4:0] SUB_DEC    = 5'b00001;
  localparam logic [4:0] SUB_ENCROT = 5'b00010;
  localparam logic [4:0] SUB_DECROT = 5'b00011;
  localparam logic [4:0] MIX_ENC    = 5'b00100;
  localparam logic [4:0] MIX_DEC    = 5'b00101;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic [2:0]  ivalid;
  logic [2:0]  idone;
  logic [2:0]  busy;
  logic [31:0] rs1, rs2;
  logic [4:0]  sub;
  logic [3:0]  ben   [3];
  logic [31:0] wdata [3];
  logic [1:0]  dbg   [3];

  int n_pass  = 0;
  int n_total = 0;
  int lat_exp [3] = '{5, 3, 2};

  typedef struct {
    logic [4:0]  sub;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] data;
    logic [3:0]  ben;
    bit          unsup;
    bit          chg;
  } vec_t;

  vec_t vecs [14];

  always #5 g_clk = ~g_clk;

  scarv_cop_aes_lanes #(.LANES(1)) u_dut1 (
    .g_clk(g_clk), .g_reset(g_reset), .aes_ivalid(ivalid[0]), .aes_idone(idone[0]),
    .aes_busy(busy[0]), .aes_rs1(rs1), .aes_rs2(rs2), .id_subclass(sub),
    .aes_cpr_rd_ben(ben[0]), .aes_cpr_rd_wdata(wdata[0]), .dbg_state(dbg[0]));

  scarv_cop_aes_lanes #(.LANES(2)) u_dut2 (
    .g_clk(g_clk), .g_reset(g_reset), .aes_ivalid(ivalid[1]), .aes_idone(idone[1]),
    .aes_busy(busy[1]), .aes_rs1(rs1), .aes_rs2(rs2), .id_subclass(sub),
    .aes_cpr_rd_ben(ben[1]), .aes_cpr_rd_wdata(wdata[1]), .dbg_state(dbg[1]));

  scarv_cop_aes_lanes #(.LANES(4)) u_dut4 (
    .g_clk(g_clk), .g_reset(g_reset), .aes_ivalid(ivalid[2]), .aes_idone(idone[2]),
    .aes_busy(busy[2]), .aes_rs1(rs1), .aes_rs2(rs2), .id_subclass(sub),
    .aes_cpr_rd_ben(ben[2]), .aes_cpr_rd_wdata(wdata[2]), .dbg_state(dbg[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_idone_d%0d", tag, d), {31'b0, idone[d]}, 32'h0);
      check($sformatf("%s_busy_d%0d", tag, d), {31'b0, busy[d]}, 32'h0);
      check($sformatf("%s_ben_d%0d", tag, d), {28'b0, ben[d]}, 32'h0);
      check($sformatf("%s_wdata_d%0d", tag, d), wdata[d], 32'h0);
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int          lat   [3];
    int          pulses[3];
    logic [31:0] got_d [3];
    logic [3:0]  got_b [3];
    int          el;
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; pulses[d] = 0; got_d[d] = 32'hx; got_b[d] = 4'hx;
    end
    @(posedge g_clk); #1;
    rs1 = v.rs1; rs2 = v.rs2; sub = v.sub; ivalid = 3'b111;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge g_clk); #1;
      if (v.chg) begin
        rs1 = $urandom; rs2 = $urandom; sub = 5'($urandom_range(0, 31));
      end
      @(negedge g_clk);
      for (int d = 0; d < 3; d++) begin
        if (idone[d]) begin
          pulses[d]++;
          if (lat[d] < 0) begin
            lat[d] = cyc; got_d[d] = wdata[d]; got_b[d] = ben[d];
          end
          ivalid[d] = 1'b0;
        end
      end
    end
    ivalid = 3'b000;
    for (int d = 0; d < 3; d++) begin
      el = v.unsup ? 1 : lat_exp[d];
      check($sformatf("v%0d_latency_d%0d", vi, d), lat[d], el);
      check($sformatf("v%0d_wdata_d%0d", vi, d), got_d[d], v.data);
      check($sformatf("v%0d_ben_d%0d", vi, d), {28'b0, got_b[d]}, {28'b0, v.ben});
      check($sformatf("v%0d_pulses_d%0d", vi, d), pulses[d], 1);
    end
  endtask

  initial begin
    int n_done;
    int c1 [3], c2 [3], nb [3];
    logic [31:0] d1 [3], d2 [3];

    vecs[0]  = '{SUB_ENC,    32'h00000001, 32'h00000000, 32'h6363637C, 4'hF, 1'b0, 1'b0};
    vecs[1]  = '{SUB_ENCROT, 32'h00000001, 32'h00000000, 32'h63637C63, 4'hF, 1'b0, 1'b0};
    vecs[2]  = '{SUB_DEC,    32'h63636363, 32'h63636363, 32'h00000000, 4'hF, 1'b0, 1'b0};
    vecs[3]  = '{MIX_ENC,    32'h005300DB, 32'h45001300, 32'h8E4DA1BC, 4'hF, 1'b0, 1'b0};
    vecs[4]  = '{MIX_DEC,    32'h00A1008E, 32'hBC004D00, 32'hDB135345, 4'hF, 1'b0, 1'b0};
    vecs[5]  = '{MIX_ENC,    32'h002200F2, 32'h5C000A00, 32'h9FDC589D, 4'hF, 1'b0, 1'b0};
    vecs[6]  = '{MIX_DEC,    32'h0058009F, 32'h9D00DC00, 32'hF20A225C, 4'hF, 1'b0, 1'b0};
    vecs[7]  = '{SUB_DEC,    32'h0000007C, 32'h00000000, 32'h52525201, 4'hF, 1'b0, 1'b0};
    vecs[8]  = '{SUB_DECROT, 32'h0000007C, 32'h00000000, 32'h52520152, 4'hF, 1'b0, 1'b0};
    vecs[9]  = '{SUB_ENC,    32'h00530001, 32'h00000000, 32'h63ED637C, 4'hF, 1'b0, 1'b1};
    vecs[10] = '{MIX_ENC,    32'h00D400D4, 32'hD500D400, 32'hD5D5D7D6, 4'hF, 1'b0, 1'b1};
    vecs[11] = '{5'b01000,   32'h00000001, 32'h00000000, 32'h00000000, 4'h0, 1'b1, 1'b0};
    vecs[12] = '{5'b00110,   32'h00530001, 32'h45001300, 32'h00000000, 4'h0, 1'b1, 1'b0};
    vecs[13] = '{SUB_ENC,    32'hAA00BB01, 32'h00CC00DD, 32'h6363637C, 4'hF, 1'b0, 1'b0};

    // Clock/reset
    g_reset = 1'b1; ivalid = 3'b000; rs1 = 32'h0; rs2 = 32'h0; sub = 5'h0;
    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    check_idle_outputs("reset");
    for (int d = 0; d < 3; d++) check($sformatf("reset_state_d%0d", d), {30'b0, dbg[d]}, 32'h0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Abort on LANES=1: ivalid dropped in RUN step 1.
    @(posedge g_clk); #1;
    rs1 = 32'h00000001; rs2 = 32'h0; sub = SUB_ENC; ivalid = 3'b001;
    @(posedge g_clk); #1;
    @(posedge g_clk); #1 ivalid = 3'b000;
    @(negedge g_clk);
    check("abort_busy_in_run", {31'b0, busy[0]}, 32'h1);
    @(negedge g_clk);
    check("abort_state_idle", {30'b0, dbg[0]}, 32'h0);
    check("abort_busy_low", {31'b0, busy[0]}, 32'h0);
    n_done = 0;
    repeat (8) begin @(negedge g_clk); if (idone[0]) n_done++; end
    check("abort_no_idone", n_done, 0);

    // Reset during RUN on all instances.
    @(posedge g_clk); #1;
    rs1 = 32'h005300DB; rs2 = 32'h45001300; sub = MIX_ENC; ivalid = 3'b111;
    @(posedge g_clk); #1 g_reset = 1'b1; ivalid = 3'b000;
    @(posedge g_clk); #1 g_reset = 1'b0;
    @(negedge g_clk);
    check_idle_outputs("midreset");
    n_done = 0;
    repeat (8) begin @(negedge g_clk); if (idone != 3'b000) n_done++; end
    check("midreset_no_idone", n_done, 0);

    // Back-to-back: MIX_ENC then SUB_ENC with ivalid held throughout.
    for (int d = 0; d < 3; d++) begin c1[d] = -1; c2[d] = -1; nb[d] = 0; d1[d] = 32'hx; d2[d] = 32'hx; end
    @(posedge g_clk); #1;
    rs1 = 32'h005300DB; rs2 = 32'h45001300; sub = MIX_ENC; ivalid = 3'b111;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge g_clk); #1;
      if (cyc == 1) begin rs1 = 32'h00000001; rs2 = 32'h0; sub = SUB_ENC; end
      @(negedge g_clk);
      for (int d = 0; d < 3; d++) begin
        if (ivalid[d] && idone[d]) begin
          nb[d]++;
          if (nb[d] == 1) begin c1[d] = cyc; d1[d] = wdata[d]; end
          else begin c2[d] = cyc; d2[d] = wdata[d]; ivalid[d] = 1'b0; end
        end
      end
    end
    ivalid = 3'b000;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("b2b_first_cycle_d%0d", d), c1[d], lat_exp[d]);
      check($sformatf("b2b_second_cycle_d%0d", d), c2[d], 2 * lat_exp[d] + 1);
      check($sformatf("b2b_first_data_d%0d", d), d1[d], 32'h8E4DA1BC);
      check($sformatf("b2b_second_data_d%0d", d), d2[d], 32'h6363637C);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
